// File: rtl/zrb_sck_burst_gen.sv
// rtl/zrb_sck_burst_gen.sv - burst SCK generator with phase-accumulator rate control
module zrb_sck_burst_gen #(
  parameter int INPUT_CLK = 50000000,
  parameter int RATE0     = 200000,
  parameter int RATE1     = 5000000,
  parameter int RATE2     = 10000000,
  parameter int RATE3     = 25000000,
  parameter int ACC_WIDTH = 29,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] n_cycles,
  input  logic [1:0]           rate_sel,
  input  logic                 cpol,
  output logic                 sck,
  output logic                 lead_stb,
  output logic                 trail_stb,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic signed [ACC_WIDTH-1:0] CLK_A    = ACC_WIDTH'(INPUT_CLK);
  localparam logic signed [ACC_WIDTH-1:0] ACC_INIT = -CLK_A;
  localparam logic signed [ACC_WIDTH-1:0] STEP0    = ACC_WIDTH'(2 * RATE0);
  localparam logic signed [ACC_WIDTH-1:0] STEP1    = ACC_WIDTH'(2 * RATE1);
  localparam logic signed [ACC_WIDTH-1:0] STEP2    = ACC_WIDTH'(2 * RATE2);
  localparam logic signed [ACC_WIDTH-1:0] STEP3    = ACC_WIDTH'(2 * RATE3);
  localparam logic [CNT_WIDTH:0]          LAST_EDGE = (CNT_WIDTH+1)'(1);

  state_t                       state;
  logic                         cpol_q;
  logic [1:0]                   rate_q;
  logic [CNT_WIDTH:0]           edges_left;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  step;
  logic signed [ACC_WIDTH-1:0]  sum;
  logic                         toggle;

  // Per-cycle phase increment from the rate latched at burst start; a non-negative sum means an edge is due
  always_comb begin
    step = STEP0;
    case (rate_q)
      2'd0: step = STEP0;
      2'd1: step = STEP1;
      2'd2: step = STEP2;
      default: step = STEP3;
    endcase
    sum    = acc + step;
    toggle = ~sum[ACC_WIDTH-1];
  end

  // Burst FSM: latches settings on start, toggles SCK on accumulator wrap, registers all outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      acc        <= ACC_INIT;
      cpol_q     <= 1'b0;
      rate_q     <= 2'd0;
      edges_left <= '0;
      sck        <= 1'b0;
      lead_stb   <= 1'b0;
      trail_stb  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      lead_stb  <= 1'b0;
      trail_stb <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          cpol_q <= cpol;
          sck    <= cpol;
          acc    <= ACC_INIT;
          busy   <= 1'b0;
          if (start) begin
            if (n_cycles != '0) begin
              rate_q     <= rate_sel;
              edges_left <= {n_cycles, 1'b0};
              state      <= RUN;
              busy       <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (toggle) begin
            acc        <= sum - CLK_A;
            sck        <= ~sck;
            edges_left <= edges_left - LAST_EDGE;
            if (~sck != cpol_q) begin
              lead_stb <= 1'b1;
            end else begin
              trail_stb <= 1'b1;
            end
            if (edges_left == LAST_EDGE) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            acc <= sum;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zrb_sck_burst_gen.sv
// tb/tb_zrb_sck_burst_gen.sv - self-checking bench for zrb_sck_burst_gen
module tb_zrb_sck_burst_gen;

  localparam longint CLK_HZ = 50000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] n_cycles = '0;
  logic [1:0]  rate_sel = '0;
  logic        cpol = 1'b0;
  logic        sck, lead_stb, trail_stb, busy, done;

  int total = 0;
  int bad = 0;
  longint rates [4] = '{200000, 5000000, 10000000, 25000000};

  zrb_sck_burst_gen dut (
    .clk(clk), .reset(reset), .start(start), .n_cycles(n_cycles),
    .rate_sel(rate_sel), .cpol(cpol), .sck(sck), .lead_stb(lead_stb),
    .trail_stb(trail_stb), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] obs();
    return {sck, lead_stb, trail_stb, busy, done};
  endfunction

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got {sck,lead,trail,busy,done}=%b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Number of SCK edges emitted after j RUN cycles: the k-th edge lands on RUN cycle ceil(k*CLK/(2*rate))
  function automatic longint edges_after(input longint j, input longint r, input longint n2);
    longint t;
    t = (j * 2 * r) / CLK_HZ;
    return (t > n2) ? n2 : t;
  endfunction

  task automatic burst(input int sel, input int n, input logic cp, input bit perturb, input string tag);
    longint r, n2, jend, k, kp;
    int leads, trails;
    logic e_lead, e_trail;
    r = rates[sel];
    n2 = 2 * n;
    jend = (n2 * CLK_HZ + 2 * r - 1) / (2 * r);
    leads = 0;
    trails = 0;
    kp = 0;
    cpol = cp;
    rate_sel = 2'(sel);
    n_cycles = 16'(n);
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_enter"}, obs(), {cp, 1'b0, 1'b0, 1'b1, 1'b0});
    for (longint j = 1; j <= jend; j++) begin
      if (perturb) begin
        rate_sel = 2'($urandom);
        cpol = 1'($urandom);
        start = 1'($urandom);
        n_cycles = 16'($urandom);
      end
      step();
      k = edges_after(j, r, n2);
      e_lead = (k != kp) && k[0];
      e_trail = (k != kp) && !k[0];
      leads += int'(lead_stb);
      trails += int'(trail_stb);
      chk(tag, obs(), {cp ^ k[0], e_lead, e_trail, (k < n2), (k == n2) && (k != kp)});
      kp = k;
    end
    start = 1'b0;
    cpol = cp;
    step();
    chk({tag, "_after"}, obs(), {cp, 1'b0, 1'b0, 1'b0, 1'b0});
    chk_int({tag, "_leads"}, leads, n);
    chk_int({tag, "_trails"}, trails, n);
  endtask

  initial begin
    // reset wins over start and holds sck low regardless of cpol
    reset = 1'b1;
    cpol = 1'b1;
    start = 1'b1;
    n_cycles = 16'd3;
    step();
    step();
    chk("reset_state", obs(), 5'b00000);
    start = 1'b0;
    reset = 1'b0;
    step();
    chk("idle_cpol1", obs(), 5'b10000);
    cpol = 1'b0;
    step();
    chk("idle_cpol0", obs(), 5'b00000);

    burst(2, 2, 1'b0, 1'b0, "r10m_n2");
    burst(3, 3, 1'b1, 1'b0, "r25m_n3");
    burst(0, 1, 1'b0, 1'b0, "r200k_n1");

    // zero-length burst: only a done pulse
    cpol = 1'b1;
    step();
    n_cycles = 16'd0;
    rate_sel = 2'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("zero_len_done", obs(), 5'b10001);
    step();
    chk("zero_len_after", obs(), 5'b10000);

    burst(1, 3, 1'b1, 1'b1, "perturbed");

    // reset in the middle of a burst aborts with no done pulse
    cpol = 1'b0;
    rate_sel = 2'd2;
    n_cycles = 16'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    chk("mid_busy", {4'b0, busy}, 5'b00001);
    cpol = 1'b1;
    reset = 1'b1;
    step();
    chk("mid_reset", obs(), 5'b00000);
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("post_abort", obs(), 5'b10000);
    end

    for (int b = 0; b < 1000; b++) begin
      burst(int'($urandom_range(3, 1)), int'($urandom_range(3, 1)), 1'($urandom),
            1'($urandom), "rand");
    end
    burst(0, 2, 1'b1, 1'b1, "r200k_n2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
